// File: rtl/pe_array_sched_pkg.sv
// pe_array_pkg: shared types and defaults for the PE-array pass scheduler.
//   sched_state_t : scheduler FSM states
//   DEF_*         : default array geometry
//   num_out()     : valid outputs of a 1-D valid convolution
package pe_array_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLEAR,
        S_ISSUE,
        S_WAIT_MAC,
        S_DRAIN,
        S_DONE
    } sched_state_t;

    localparam int DEF_NUM_PE    = 14;
    localparam int DEF_FILT_LEN  = 3;
    localparam int DEF_IFMAP_LEN = 8;
    localparam int DEF_ADDR_W    = 8;

    function automatic int num_out(input int ifmap_len, input int filt_len);
        return ifmap_len - filt_len + 1;
    endfunction

endpackage

// File: rtl/pe_array_sched_if.sv
// pe_array_sched_if: scheduler <-> scratchpad / PE row / consumer signals.
//   master : scheduler side (drives requests, clears, MAC enable, drain index)
//   slave  : environment side (drives start, mem_ready, out_ready)
// Optional macro PE_SCHED_PERF_EN adds perf_cycles / perf_stalls.
interface pe_array_sched_if #(
    parameter int ADDR_W = 8,
    parameter int IDX_W  = 4
);
    logic              start;
    logic              mem_ready;
    logic              w_rd_en;
    logic [ADDR_W-1:0] w_rd_addr;
    logic              x_rd_en;
    logic [ADDR_W-1:0] x_rd_base;
    logic              psum_clr;
    logic              mac_en;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic              out_ready;
    logic              busy;
    logic              done;
`ifdef PE_SCHED_PERF_EN
    logic [31:0]       perf_cycles;
    logic [31:0]       perf_stalls;
`endif

    modport master (
        input  start, mem_ready, out_ready,
`ifdef PE_SCHED_PERF_EN
        output perf_cycles, perf_stalls,
`endif
        output w_rd_en, w_rd_addr, x_rd_en, x_rd_base, psum_clr, mac_en,
        output out_valid, out_idx, busy, done
    );

    modport slave (
        output start, mem_ready, out_ready,
`ifdef PE_SCHED_PERF_EN
        input  perf_cycles, perf_stalls,
`endif
        input  w_rd_en, w_rd_addr, x_rd_en, x_rd_base, psum_clr, mac_en,
        input  out_valid, out_idx, busy, done
    );

endinterface

// File: rtl/pe_array_sched_drain.sv
// pe_sched_drain: valid/ready index counter for draining COUNT results.
//   clk, rst : clock, synchronous active-low reset
//   clear    : restart the index at 0
//   valid    : producer is presenting idx
//   ready    : consumer accepts
//   idx      : current index, holds while ready==0 and at the terminal value
//   last     : handshake on the final index this cycle
module pe_sched_drain #(
    parameter int COUNT = 6,
    parameter int IDX_W = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    input  logic             valid,
    input  logic             ready,
    output logic [IDX_W-1:0] idx,
    output logic             last
);
    logic at_end;
    logic hs;

    assign at_end = (idx == IDX_W'(COUNT - 1));
    assign hs     = valid && ready;
    assign last   = hs && at_end;

    always_ff @(posedge clk) begin
        if (!rst)
            idx <= '0;
        else if (clear)
            idx <= '0;
        else if (hs && !at_end)
            idx <= idx + 1'b1;
    end

endmodule

// File: rtl/pe_array_sched.sv
// pe_array_sched: sequences one convolution pass of the 1-D PE row:
// clear psums, issue FILT_LEN weight/ifmap reads (MAC one cycle later),
// then drain NUM_OUT psums over valid/ready.
//   clk : rising-edge clock
//   rst : synchronous active-low reset (abandons any pass, no done)
//   bus : pe_array_sched_if.master (start, scratchpad reads, psum_clr,
//         mac_en, out_valid/out_idx/out_ready, busy, done)
// Optional macro PE_SCHED_PERF_EN adds perf_cycles / perf_stalls.
module pe_array_sched
    import pe_array_pkg::*;
#(
    parameter int NUM_PE    = DEF_NUM_PE,
    parameter int FILT_LEN  = DEF_FILT_LEN,
    parameter int IFMAP_LEN = DEF_IFMAP_LEN,
    parameter int NUM_OUT   = num_out(IFMAP_LEN, FILT_LEN),
    parameter int ADDR_W    = DEF_ADDR_W
) (
    input  logic           clk,
    input  logic           rst,
    pe_array_sched_if.master bus
);
    localparam int IDX_W = $clog2(NUM_PE);
    localparam int K_W   = (FILT_LEN > 1) ? $clog2(FILT_LEN) : 1;

    generate
        if (NUM_OUT > NUM_PE || NUM_OUT < 1) begin : g_bad_geom
            $error("pe_array_sched: NUM_OUT must be in 1..NUM_PE");
        end
    endgenerate

    sched_state_t      state, state_nxt;
    logic [K_W-1:0]    k;
    logic              k_last;
    logic              issue_ok;
    logic              mac_q;
    logic [IDX_W-1:0]  idx;
    logic              drain_last;

    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic              psum_clr;
    logic              out_valid;
    logic [IDX_W-1:0]  out_idx;
    logic              done;

    assign k_last   = (k == K_W'(FILT_LEN - 1));
    assign issue_ok = (state == S_ISSUE) && bus.mem_ready;

    always_ff @(posedge clk) begin
        if (!rst)
            state <= S_IDLE;
        else
            state <= state_nxt;
    end

    // Outputs decode only the registered state/counters, so they are glitch-free
    // Moore outputs; mac_en is the separately registered issue handshake.
    always_comb begin
        state_nxt = state;
        rd_en     = 1'b0;
        rd_addr   = '0;
        psum_clr  = 1'b0;
        out_valid = 1'b0;
        out_idx   = '0;
        done      = 1'b0;
        case (state)
            S_IDLE:     if (bus.start) state_nxt = S_CLEAR;
            S_CLEAR: begin
                psum_clr  = 1'b1;
                state_nxt = S_ISSUE;
            end
            S_ISSUE: begin
                rd_en   = 1'b1;
                rd_addr = ADDR_W'(k);
                if (bus.mem_ready && k_last) state_nxt = S_WAIT_MAC;
            end
            S_WAIT_MAC: state_nxt = S_DRAIN;
            S_DRAIN: begin
                out_valid = 1'b1;
                out_idx   = idx;
                if (drain_last) state_nxt = S_DONE;
            end
            S_DONE: begin
                done      = 1'b1;
                state_nxt = S_IDLE;
            end
            default:    state_nxt = S_IDLE;
        endcase
    end

    // Tap counter: holds at FILT_LEN-1 on the final acceptance rather than wrapping.
    always_ff @(posedge clk) begin
        if (!rst)
            k <= '0;
        else if (state == S_CLEAR)
            k <= '0;
        else if (issue_ok && !k_last)
            k <= k + 1'b1;
    end

    // Scratchpad read latency is one cycle, so the PEs see data the cycle after acceptance.
    always_ff @(posedge clk) begin
        if (!rst)
            mac_q <= 1'b0;
        else
            mac_q <= issue_ok;
    end

    pe_sched_drain #(
        .COUNT (NUM_OUT),
        .IDX_W (IDX_W)
    ) u_drain (
        .clk   (clk),
        .rst   (rst),
        .clear (state == S_CLEAR),
        .valid (state == S_DRAIN),
        .ready (bus.out_ready),
        .idx   (idx),
        .last  (drain_last)
    );

    assign bus.w_rd_en   = rd_en;
    assign bus.w_rd_addr = rd_addr;
    assign bus.x_rd_en   = rd_en;
    assign bus.x_rd_base = rd_addr;
    assign bus.psum_clr  = psum_clr;
    assign bus.mac_en    = mac_q;
    assign bus.out_valid = out_valid;
    assign bus.out_idx   = out_idx;
    assign bus.busy      = (state != S_IDLE);
    assign bus.done      = done;

`ifdef PE_SCHED_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stalls;
    logic        stall;

    assign stall = ((state == S_ISSUE) && !bus.mem_ready) ||
                   ((state == S_DRAIN) && !bus.out_ready);

    // Cleared on the edge entering CLEAR so the CLEAR cycle itself is counted;
    // left untouched in IDLE so software can read the last pass.
    always_ff @(posedge clk) begin
        if (!rst) begin
            perf_cycles <= '0;
            perf_stalls <= '0;
        end else if (state == S_IDLE) begin
            if (state_nxt == S_CLEAR) begin
                perf_cycles <= '0;
                perf_stalls <= '0;
            end
        end else begin
            if (perf_cycles != '1)         perf_cycles <= perf_cycles + 1'b1;
            if (stall && perf_stalls != '1) perf_stalls <= perf_stalls + 1'b1;
        end
    end

    assign bus.perf_cycles = perf_cycles;
    assign bus.perf_stalls = perf_stalls;
`endif

endmodule

// File: tb/tb_pe_array_sched.sv
// Testbench for pe_array_sched. The reference model builds the expected
// per-cycle timeline of a pass from the per-cycle mem_ready/out_ready
// stimulus and compares every cycle's outputs against it.
module tb_pe_array_sched;
    import pe_array_pkg::*;

    localparam int F    = DEF_FILT_LEN;
    localparam int NO   = num_out(DEF_IFMAP_LEN, DEF_FILT_LEN);
    localparam int MAXC = 256;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    pe_array_sched_if #(.ADDR_W(8), .IDX_W(4)) bus ();

    pe_array_sched dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks = 0;
    int errors = 0;

    // Stimulus for cycle c of a pass (cycle 1 = first cycle after start is sampled).
    bit mr[MAXC], orr[MAXC], st[MAXC];
    // Expected timeline.
    bit e_clr[MAXC], e_rd[MAXC], e_mac[MAXC], e_vld[MAXC], e_busy[MAXC], e_done[MAXC];
    int e_addr[MAXC], e_idx[MAXC];
    int done_cyc, stall_cnt;

    function automatic logic [26:0] observe();
        return {bus.psum_clr, bus.w_rd_en, bus.x_rd_en, bus.w_rd_addr, bus.x_rd_base,
                bus.mac_en, bus.out_valid, bus.out_idx, bus.busy, bus.done};
    endfunction

    function automatic void stim_ones();
        for (int i = 0; i < MAXC; i++) begin
            mr[i] = 1'b1; orr[i] = 1'b1; st[i] = 1'b0;
        end
    endfunction

    function automatic void stim_random(input bit rnd_start);
        for (int i = 0; i < MAXC; i++) begin
            mr[i]  = (i >= 150) || ($urandom_range(3) != 0);
            orr[i] = (i >= 150) || ($urandom_range(2) != 0);
            st[i]  = rnd_start && ($urandom_range(1) == 1);
        end
    endfunction

    // Walk the pass: one cycle of CLEAR, each tap waits for mem_ready, one
    // wait cycle, each output waits for out_ready, then the done cycle.
    function automatic void build_model();
        int c;
        for (int i = 0; i < MAXC; i++) begin
            e_clr[i] = 0; e_rd[i] = 0; e_mac[i] = 0; e_vld[i] = 0;
            e_busy[i] = 0; e_done[i] = 0; e_addr[i] = 0; e_idx[i] = 0;
        end
        stall_cnt = 0;
        e_clr[1] = 1;
        c = 2;
        for (int k = 0; k < F; k++) begin
            while (c < MAXC - 4) begin
                e_rd[c] = 1; e_addr[c] = k;
                if (mr[c]) begin
                    e_mac[c + 1] = 1;
                    c++;
                    break;
                end
                stall_cnt++;
                c++;
            end
        end
        c++;
        for (int i = 0; i < NO; i++) begin
            while (c < MAXC - 4) begin
                e_vld[c] = 1; e_idx[c] = i;
                if (orr[c]) begin
                    c++;
                    break;
                end
                stall_cnt++;
                c++;
            end
        end
        e_done[c] = 1;
        done_cyc  = c;
        for (int j = 1; j <= c; j++) e_busy[j] = 1;
    endfunction

    function automatic logic [26:0] expect_at(input int c);
        return {e_clr[c], e_rd[c], e_rd[c], 8'(e_addr[c]), 8'(e_addr[c]),
                e_mac[c], e_vld[c], 4'(e_idx[c]), e_busy[c], e_done[c]};
    endfunction

    // Entered just after a negedge with the DUT idle; returns after the
    // negedge of the first idle cycle following done.
    task automatic run_pass(input string tag);
        logic [26:0] obs, exp_v;
        int ndone;
        build_model();
        ndone = 0;
        bus.start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= done_cyc + 1; c++) begin
            #1;
            bus.start     = (c <= done_cyc) ? st[c] : 1'b0;
            bus.mem_ready = mr[c];
            bus.out_ready = orr[c];
            @(negedge clk);
            obs   = observe();
            exp_v = expect_at(c);
            if (bus.done === 1'b1) ndone++;
            checks++;
            if (obs !== exp_v) begin
                errors++;
                $display("FAIL %s cycle %0d: got %h expected %h", tag, c, obs, exp_v);
            end
            if (c <= done_cyc) @(posedge clk);
        end
        checks++;
        if (ndone !== 1) begin
            errors++;
            $display("FAIL %s done_count: got %0d expected 1", tag, ndone);
        end
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (bus.perf_cycles !== 32'(done_cyc) || bus.perf_stalls !== 32'(stall_cnt)) begin
            errors++;
            $display("FAIL %s perf: got cycles=%0d stalls=%0d expected cycles=%0d stalls=%0d",
                     tag, bus.perf_cycles, bus.perf_stalls, done_cyc, stall_cnt);
        end
`endif
    endtask

    task automatic test_reset();
        bus.start = 1'b1; bus.mem_ready = 1'b1; bus.out_ready = 1'b1;
        rst = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if (observe() !== 27'd0) begin
            errors++;
            $display("FAIL reset_outputs: got %h expected 0", observe());
        end
`ifdef PE_SCHED_PERF_EN
        checks++;
        if (bus.perf_cycles !== 32'd0 || bus.perf_stalls !== 32'd0) begin
            errors++;
            $display("FAIL reset_perf: got %0d/%0d expected 0/0", bus.perf_cycles, bus.perf_stalls);
        end
`endif
        bus.start = 1'b0;
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (observe() !== 27'd0) begin
            errors++;
            $display("FAIL idle_after_reset: got %h expected 0", observe());
        end
    endtask

    task automatic test_nominal();
        stim_ones();
        run_pass("nominal");
    endtask

    task automatic test_mem_stall();
        stim_ones();
        mr[3] = 1'b0; mr[4] = 1'b0;
        run_pass("mem_stall");
    endtask

    task automatic test_out_toggle();
        stim_ones();
        for (int i = 0; i < MAXC; i++) orr[i] = (i % 2 == 1);
        run_pass("out_toggle");
    endtask

    task automatic test_start_ignored();
        stim_ones();
        for (int i = 1; i < MAXC; i++) st[i] = 1'b1;
        orr[7] = 1'b0; orr[8] = 1'b0;
        run_pass("start_ignored");
    endtask

    task automatic test_back_to_back();
        stim_random(1'b0);
        run_pass("b2b_a");
        stim_random(1'b1);
        run_pass("b2b_b");
    endtask

    task automatic test_reset_in_drain();
        logic [26:0] obs;
        stim_ones();
        build_model();
        bus.start = 1'b1;
        @(posedge clk);
        // Cycle 9 is DRAIN with out_idx==3; reset is sampled at the end of it.
        for (int c = 1; c <= 9; c++) begin
            #1;
            bus.start = 1'b0; bus.mem_ready = 1'b1; bus.out_ready = 1'b1;
            if (c == 9) rst = 1'b0;
            @(negedge clk);
            obs = observe();
            checks++;
            if (obs !== expect_at(c)) begin
                errors++;
                $display("FAIL rst_drain_pre cycle %0d: got %h expected %h", c, obs, expect_at(c));
            end
            @(posedge clk);
        end
        #1 rst = 1'b1;
        for (int c = 10; c <= 14; c++) begin
            @(negedge clk);
            checks++;
            if (observe() !== 27'd0) begin
                errors++;
                $display("FAIL rst_drain_idle cycle %0d: got %h expected 0", c, observe());
            end
`ifdef PE_SCHED_PERF_EN
            checks++;
            if (bus.perf_cycles !== 32'd0 || bus.perf_stalls !== 32'd0) begin
                errors++;
                $display("FAIL rst_drain_perf: got %0d/%0d expected 0/0", bus.perf_cycles, bus.perf_stalls);
            end
`endif
            if (c < 14) @(posedge clk);
        end
        stim_ones();
        run_pass("after_rst");
    endtask

    task automatic test_random();
        for (int n = 0; n < 6; n++) begin
            stim_random(n[0]);
            run_pass($sformatf("random%0d", n));
        end
    endtask

    initial begin
        bus.start = 1'b0; bus.mem_ready = 1'b0; bus.out_ready = 1'b0;
        test_reset();
        test_nominal();
        test_mem_stall();
        test_out_toggle();
        test_start_ignored();
        test_back_to_back();
        test_reset_in_drain();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation exceeded time limit");
        $fatal(1, "timeout");
    end

endmodule

// File: doc/pe_array_sched.md
Name: pe_array_sched

Overview:
- Sequences one convolution pass of the 1-D row-stationary PE array in `main`.
- Pass order: clear PE psum accumulators, issue FILT_LEN weight/ifmap scratchpad reads with a broadcast MAC enable, then drain the NUM_OUT psum results one at a time over a valid/ready port.
- Replaces the hard-wired FSM sequence inside `main`; `main` instantiates it between the scratchpads and the PE row.

Parameters:
- NUM_PE, 14, physical PEs in the row; the psum_outs vector width.
- FILT_LEN, 3, filter taps; number of MAC issue cycles per pass.
- IFMAP_LEN, 8, ifmap row length.
- NUM_OUT, IFMAP_LEN-FILT_LEN+1 (6), valid outputs per pass. Elaboration error if NUM_OUT > NUM_PE or NUM_OUT < 1.
- ADDR_W, 8, scratchpad address width.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  reset, synchronous, active-low.
- start  in  1  begin a pass; sampled only in IDLE.
- mem_ready  in  1  scratchpad read grant for the current issue.
- w_rd_en  out  1  weight read request.
- w_rd_addr  out  ADDR_W  tap index k.
- x_rd_en  out  1  ifmap read request; PE i reads x_rd_base+i.
- x_rd_base  out  ADDR_W  ifmap window base (= k).
- psum_clr  out  1  clear all PE accumulators.
- mac_en  out  1  PEs accumulate w*x this cycle.
- out_valid  out  1  out_idx selects a finished psum.
- out_idx  out  $clog2(NUM_PE)  PE index being drained.
- out_ready  in  1  consumer accepts the psum.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse at pass end.

Behaviour:
- Reset: rst==0 at a clk edge → state IDLE. All outputs 0, internal counters 0. Applies mid-pass too; the partial pass is abandoned and done is not pulsed.
- States: IDLE, CLEAR, ISSUE, WAIT_MAC, DRAIN, DONE. Outputs are registered (Moore) except mac_en, which is a one-cycle-delayed register of the issue handshake.
- IDLE → CLEAR on start==1. Start in any other state is ignored, not queued.
- CLEAR: psum_clr=1 for exactly one cycle; k←0; → ISSUE.
- ISSUE:
  - w_rd_en=x_rd_en=1, w_rd_addr=x_rd_base=k.
  - Issue accepted when mem_ready==1. k increments on each acceptance.
  - mem_ready==0 holds the request and address unchanged (stall, no limit).
  - Acceptance of k==FILT_LEN-1 → WAIT_MAC.
- mac_en is 1 exactly in the cycle after each accepted issue (1-cycle read latency). FILT_LEN pulses total, non-contiguous if stalls occur.
- WAIT_MAC: no requests; mac_en high for the last tap; → DRAIN.
- DRAIN:
  - out_valid=1, out_idx starts at 0.
  - Handshake = out_valid && out_ready; advances out_idx.
  - out_idx and out_valid are held stable while out_ready==0.
  - Handshake at out_idx==NUM_OUT-1 → DONE.
- DONE: done=1 and busy=1 for one cycle; → IDLE.
- Nominal latency with mem_ready=out_ready=1 and start sampled at edge 0:
  - CLEAR in cycle 1, ISSUE in cycles 2..FILT_LEN+1.
  - DRAIN takes NUM_OUT cycles.
  - done in cycle FILT_LEN+NUM_OUT+3 (12 with defaults).
- Counters never wrap past their terminal values.
- PEs with index ≥ NUM_OUT are never drained.

Optional Feature:
- Macro: PE_SCHED_PERF_EN.
- Defined:
  - Adds outputs perf_cycles (32) and perf_stalls (32).
  - perf_cycles counts busy cycles of the last pass.
  - perf_stalls counts ISSUE cycles with mem_ready==0 plus DRAIN cycles with out_ready==0.
  - Both counters clear on CLEAR entry, freeze in IDLE, reset to 0, and saturate at all-ones.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Decomposition:
- Package pe_array_pkg:
  - sched_state_t enum (six states).
  - Default NUM_PE/FILT_LEN/IFMAP_LEN constants.
  - Function num_out(ifmap_len, filt_len).
- One natural sub-module, pe_sched_drain: the valid/ready index counter. Reusable for the future multi-row output drainer.

Test Plan:
- Defaults, start pulse, mem_ready=out_ready=1:
  - psum_clr in cycle 1 only.
  - w_rd_addr 0,1,2 in cycles 2–4; mac_en in cycles 3–5.
  - out_idx 0..5 in cycles 6–11; done in cycle 12; busy high cycles 1–12.
- mem_ready low for 2 cycles during k=1:
  - w_rd_addr holds at 1 for 3 cycles.
  - mac_en pulses still total 3; done in cycle 14.
- out_ready toggling 1,0,1,0…:
  - each out_idx held ≥2 cycles, no index skipped or repeated.
  - done follows the 6th handshake.
- start asserted again during ISSUE and DRAIN: ignored, exactly one done. Start in the cycle after done begins a new pass with psum_clr.
- rst=0 for one cycle while in DRAIN with out_idx=3:
  - next cycle all outputs 0, state IDLE, no done pulse.
  - a fresh start then completes a full pass normally.
- With PE_SCHED_PERF_EN defined, rerun the mem_ready-stall scenario: perf_cycles=14, perf_stalls=2 after done.
